// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//
// Shares one UART transmitter between NUM_REQ byte requesters. In IDLE a
// round-robin search (starting just above the previous winner) picks one
// requester and accepts its byte combinationally. The byte is held in a single
// output register and offered to the transmitter in SEND until it is taken.
// Throughput is therefore at most one byte every two cycles.
//
// Optional feature, selected by the macro UART_ARB_LOCK_EN:
//   When defined, a byte accepted with req_last=0 locks the transmitter to the
//   same requester. The arbiter stays in LOCKED between that requester's bytes
//   until a byte with req_last=1 has been sent. When the macro is undefined,
//   req_last is ignored and every byte is arbitrated on its own.
//
// Parameters
//   NUM_REQ  number of requesters (2..8)
//   DATA_W   byte width
//
// Ports
//   clk        sole clock, rising edge
//   reset      synchronous, active-high
//   req_valid  per-requester byte present
//   req_data   requester i byte at [i*DATA_W +: DATA_W]
//   req_last   per-requester end-of-message flag (lock build only)
//   req_ready  per-requester accept strobe, at most one bit high
//   tx_valid   byte offered to the transmitter
//   tx_data    byte being offered
//   tx_ready   transmitter accepts tx_data
//   grant_id   requester owning the current/last transfer
//   busy       high whenever the arbiter is not IDLE
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data,
    input  logic [NUM_REQ-1:0]         req_last,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       tx_valid,
    output logic [DATA_W-1:0]          tx_data,
    input  logic                       tx_ready,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy
);

    localparam int ID_W = $clog2(NUM_REQ);

`ifdef UART_ARB_LOCK_EN
    typedef enum logic [1:0] {
        IDLE,
        SEND,
        LOCKED
    } state_t;
`else
    typedef enum logic {
        IDLE,
        SEND
    } state_t;
`endif

    state_t state;
    state_t state_next;

    logic [ID_W-1:0]   last_grant;
    logic [ID_W-1:0]   rr_winner;
    logic              rr_found;
    logic              accept;
    logic [ID_W-1:0]   accept_id;
    logic [DATA_W-1:0] req_bytes [NUM_REQ];

`ifdef UART_ARB_LOCK_EN
    // End-of-message flag of the byte currently held for transmission; decides
    // between IDLE and LOCKED once that byte has been taken.
    logic last_flag;
`else
    logic unused_last;
    assign unused_last = ^req_last;
`endif

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign req_bytes[i] = req_data[i*DATA_W +: DATA_W];
    end

    // Round-robin search: the candidate one above last_grant has the highest
    // priority, wrapping through all requesters, so last_grant itself is
    // considered last. After reset last_grant is NUM_REQ-1, giving requester 0
    // first priority.
    always_comb begin
        logic [ID_W-1:0] idx;
        rr_found  = 1'b0;
        rr_winner = '0;
        idx       = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = ID_W'((int'(last_grant) + k) % NUM_REQ);
            if (!rr_found && req_valid[idx]) begin
                rr_found  = 1'b1;
                rr_winner = idx;
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (rr_found) begin
                    state_next = SEND;
                end
            end
            SEND: begin
                if (tx_ready) begin
`ifdef UART_ARB_LOCK_EN
                    state_next = last_flag ? IDLE : LOCKED;
`else
                    state_next = IDLE;
`endif
                end
            end
`ifdef UART_ARB_LOCK_EN
            LOCKED: begin
                if (req_valid[last_grant]) begin
                    state_next = SEND;
                end
            end
`endif
            default: state_next = IDLE;
        endcase
    end

    // Output logic. req_ready is held low while reset is asserted so no
    // requester believes a byte was taken on an edge that discards it.
    always_comb begin
        req_ready = '0;
        tx_valid  = (state == SEND);
        busy      = (state != IDLE);
        if (!reset) begin
            case (state)
                IDLE: begin
                    if (rr_found) begin
                        req_ready[rr_winner] = 1'b1;
                    end
                end
`ifdef UART_ARB_LOCK_EN
                LOCKED: begin
                    req_ready[last_grant] = req_valid[last_grant];
                end
`endif
                default: req_ready = '0;
            endcase
        end
    end

    // A byte is accepted whenever the single raised ready bit meets its valid.
    // In IDLE the accepted requester is the round-robin winner; in LOCKED it is
    // always the lock owner, which is the previous winner.
    always_comb begin
        accept = |(req_ready & req_valid);
`ifdef UART_ARB_LOCK_EN
        accept_id = (state == LOCKED) ? last_grant : rr_winner;
`else
        accept_id = rr_winner;
`endif
    end

    // Byte buffer and grant bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_data    <= '0;
            grant_id   <= '0;
            last_grant <= ID_W'(NUM_REQ - 1);
`ifdef UART_ARB_LOCK_EN
            last_flag  <= 1'b0;
`endif
        end else if (accept) begin
            tx_data    <= req_bytes[accept_id];
            grant_id   <= accept_id;
            last_grant <= accept_id;
`ifdef UART_ARB_LOCK_EN
            last_flag  <= req_last[accept_id];
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
//
// Drives uart_tx_arbiter with directed scenarios and then randomized traffic.
// A reference model, kept as a few flags plus a queue, predicts per cycle
// which requester is accepted and pushes the expected {id, byte} into a
// scoreboard. A separate monitor compares the transmitter side against the
// head of that scoreboard whenever tx_valid is high.
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 8;

    logic                       clk = 1'b0;
    logic                       reset;
    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ*DATA_W-1:0]  req_data;
    logic [NUM_REQ-1:0]         req_last;
    logic [NUM_REQ-1:0]         req_ready;
    logic                       tx_valid;
    logic [DATA_W-1:0]          tx_data;
    logic                       tx_ready;
    logic [$clog2(NUM_REQ)-1:0] grant_id;
    logic                       busy;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NUM_REQ(NUM_REQ),
        .DATA_W (DATA_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req_valid(req_valid),
        .req_data (req_data),
        .req_last (req_last),
        .req_ready(req_ready),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .tx_ready (tx_ready),
        .grant_id (grant_id),
        .busy     (busy)
    );

    typedef struct {
        int id;
        int data;
    } exp_t;

    exp_t sb[$];
    int   obs_ids[$];
    int   obs_data[$];

    int checks   = 0;
    int failures = 0;

    // Reference model: is a byte waiting for the transmitter, is the
    // transmitter locked to one requester, and who won last.
    bit m_pending   = 1'b0;
    bit m_locked    = 1'b0;
    bit m_last_flag = 1'b0;
    int m_last      = NUM_REQ - 1;
    int m_owner     = 0;

    int tv_count = 0;
    int r2_count = 0;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     name, actual, actual, expected, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic [NUM_REQ-1:0] v,
                                 input logic [NUM_REQ*DATA_W-1:0] d,
                                 input logic [NUM_REQ-1:0] l, input logic tr);
        @(posedge clk);
        #1;
        reset     = rst;
        req_valid = v;
        req_data  = d;
        req_last  = l;
        tx_ready  = tr;
        @(negedge clk);
    endtask

    // Predict this cycle's handshake from the model state, compare the
    // requester side, then advance the model across the coming edge.
    task automatic modelStep();
        logic [NUM_REQ-1:0] exp_ready;
        int w;
        int idx;
        exp_ready = '0;
        w         = -1;
        if (!m_pending && !reset) begin
            if (m_locked) begin
                if (req_valid[m_owner[1:0]]) w = m_owner;
            end else begin
                for (int k = 1; k <= NUM_REQ; k++) begin
                    idx = (m_last + k) % NUM_REQ;
                    if (w < 0 && req_valid[idx[1:0]]) w = idx;
                end
            end
            if (w >= 0) exp_ready[w[1:0]] = 1'b1;
        end
        checkOutput("req_ready", int'(req_ready), int'(exp_ready));
        checkOutput("tx_valid", int'(tx_valid), int'(m_pending));
        checkOutput("busy", int'(busy), int'(m_pending || m_locked));
        if (tx_valid === 1'b1) tv_count++;
        if (req_ready[2] === 1'b1) r2_count++;

        if (reset) begin
            sb.delete();
            m_pending = 1'b0;
            m_locked  = 1'b0;
            m_last    = NUM_REQ - 1;
        end else if (m_pending) begin
            if (tx_ready) begin
                m_pending = 1'b0;
`ifdef UART_ARB_LOCK_EN
                m_locked = !m_last_flag;
`endif
            end
        end else if (w >= 0) begin
            sb.push_back('{w, int'(req_data[w*DATA_W +: DATA_W])});
            m_pending   = 1'b1;
            m_last      = w;
            m_owner     = w;
            m_last_flag = req_last[w[1:0]];
            m_locked    = 1'b0;
        end
    endtask

    task automatic cycle(input logic rst, input logic [NUM_REQ-1:0] v,
                         input logic [NUM_REQ*DATA_W-1:0] d,
                         input logic [NUM_REQ-1:0] l, input logic tr);
        applyStimulus(rst, v, d, l, tr);
        modelStep();
    endtask

    // Monitor: while a byte is offered, exactly one expectation must be
    // outstanding and the offered byte/id must match it; a taken byte retires it.
    always @(negedge clk) begin
        if (reset === 1'b0 && tx_valid === 1'b1) begin
            checkOutput("sb_occupancy", sb.size(), 1);
            if (sb.size() > 0) begin
                checkOutput("tx_data", int'(tx_data), sb[0].data);
                checkOutput("grant_id", int'(grant_id), sb[0].id);
                if (tx_ready === 1'b1) begin
                    obs_ids.push_back(int'(grant_id));
                    obs_data.push_back(int'(tx_data));
                    void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        int b;
        int bv;
        int exp_alt [4];

        reset     = 1'b1;
        req_valid = 4'b1111;
        req_data  = 32'h44332211;
        req_last  = 4'hF;
        tx_ready  = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        checkOutput("rst_tx_valid", int'(tx_valid), 0);
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_tx_data", int'(tx_data), 0);
        checkOutput("rst_grant_id", int'(grant_id), 0);
        checkOutput("rst_req_ready", int'(req_ready), 0);
        cycle(1'b1, 4'b1111, 32'h44332211, 4'hF, 1'b1);

        // All requesters valid, transmitter always ready: strict rotation.
        obs_ids.delete();
        obs_data.delete();
        for (int c = 0; c < 10; c++) cycle(1'b0, 4'b1111, 32'h44332211, 4'hF, 1'b1);
        cycle(1'b0, 4'b0000, 32'h0, 4'h0, 1'b1);
        checkOutput("rr_count", obs_ids.size(), 5);
        if (obs_ids.size() == 5) begin
            for (int i = 0; i < 5; i++) begin
                checkOutput("rr_id", obs_ids[i], i % 4);
                checkOutput("rr_data", obs_data[i], 8'h11 * ((i % 4) + 1));
            end
        end

        // Single requester stalled by the transmitter for five cycles.
        obs_data.delete();
        tv_count = 0;
        r2_count = 0;
        cycle(1'b0, 4'b0100, 32'h00A50000, 4'hF, 1'b0);
        for (int c = 0; c < 5; c++) cycle(1'b0, 4'b0000, 32'h0, 4'h0, 1'b0);
        cycle(1'b0, 4'b0000, 32'h0, 4'h0, 1'b1);
        cycle(1'b0, 4'b0000, 32'h0, 4'h0, 1'b0);
        checkOutput("stall_tx_valid_cycles", tv_count, 6);
        checkOutput("stall_ready2_pulses", r2_count, 1);
        checkOutput("stall_bytes", obs_data.size(), 1);

        // Requester 1 streams four bytes, holding each until accepted.
        obs_data.delete();
        b = 0;
        for (int c = 0; c < 8; c++) begin
            bv = 16 + b;
            cycle(1'b0, (b < 4) ? 4'b0010 : 4'b0000, 32'(bv << 8), 4'hF, 1'b1);
            if (req_ready[1] === 1'b1) b++;
        end
        cycle(1'b0, 4'b0000, 32'h0, 4'h0, 1'b1);
        checkOutput("stream_count", obs_data.size(), 4);
        if (obs_data.size() == 4) begin
            for (int i = 0; i < 4; i++) checkOutput("stream_data", obs_data[i], 16 + i);
        end

        // Reset one cycle into SEND discards the byte.
        obs_ids.delete();
        obs_data.delete();
        cycle(1'b0, 4'b0100, 32'h005A0000, 4'hF, 1'b0);
        cycle(1'b1, 4'b0000, 32'h0, 4'h0, 1'b0);
        cycle(1'b0, 4'b1010, 32'hDD00BB00, 4'hF, 1'b0);
        checkOutput("post_rst_tx_valid", int'(tx_valid), 0);
        checkOutput("post_rst_busy", int'(busy), 0);
        checkOutput("post_rst_ready", int'(req_ready), 4'b0010);
        cycle(1'b0, 4'b0000, 32'h0, 4'h0, 1'b1);
        cycle(1'b0, 4'b0000, 32'h0, 4'h0, 1'b0);
        checkOutput("post_rst_bytes", obs_data.size(), 1);
        if (obs_data.size() == 1) begin
            checkOutput("post_rst_data", obs_data[0], 8'hBB);
            checkOutput("post_rst_id", obs_ids[0], 1);
        end

        // A one-cycle request during SEND is neither granted nor sent.
        obs_data.delete();
        cycle(1'b0, 4'b0001, 32'h00000077, 4'hF, 1'b0);
        cycle(1'b0, 4'b1000, 32'h99000000, 4'hF, 1'b0);
        cycle(1'b0, 4'b0000, 32'h0, 4'h0, 1'b1);
        cycle(1'b0, 4'b0000, 32'h0, 4'h0, 1'b0);
        checkOutput("pulse_bytes", obs_data.size(), 1);

        // Two requesters continuously valid without end-of-message.
        cycle(1'b1, 4'b0000, 32'h0, 4'h0, 1'b0);
        obs_ids.delete();
`ifdef UART_ARB_LOCK_EN
        exp_alt = '{0, 0, 0, 0};
`else
        exp_alt = '{0, 1, 0, 1};
`endif
        for (int c = 0; c < 8; c++) cycle(1'b0, 4'b0011, 32'h0000B1A1, 4'h0, 1'b1);
        cycle(1'b0, 4'b0000, 32'h0, 4'h0, 1'b1);
        checkOutput("alt_count", obs_ids.size(), 4);
        if (obs_ids.size() == 4) begin
            for (int i = 0; i < 4; i++) checkOutput("alt_id", obs_ids[i], exp_alt[i]);
        end

        // Randomized traffic with occasional resets.
        for (int c = 0; c < 1500; c++) begin
            cycle(1'($urandom_range(0, 99) == 0), 4'($urandom), 32'($urandom),
                  4'($urandom), 1'($urandom_range(0, 9) < 6));
        end
        for (int c = 0; c < 4; c++) cycle(1'b0, 4'b0000, 32'h0, 4'h0, 1'b1);
        checkOutput("sb_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, meaning number of requesters sharing one UART transmitter (legal 2..8).
REQ-002 Parameter DATA_W, default 8, meaning byte width per transfer.
REQ-003 Port clk  input  1  sole clock; all logic on its rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port req_valid  input  NUM_REQ  bit i: requester i presents a byte.
REQ-006 Port req_data  input  NUM_REQ*DATA_W  requester i byte at [i*DATA_W +: DATA_W].
REQ-007 Port req_last  input  NUM_REQ  bit i: requester i's byte ends its message (used only with UART_ARB_LOCK_EN).
REQ-008 Port req_ready  output  NUM_REQ  bit i: requester i's byte is accepted this cycle.
REQ-009 Port tx_valid  output  1  byte offered to the UART transmitter.
REQ-010 Port tx_data  output  DATA_W  byte to transmit.
REQ-011 Port tx_ready  input  1  transmitter accepts tx_data this cycle.
REQ-012 Port grant_id  output  $clog2(NUM_REQ)  index of the requester owning the current/last transfer.
REQ-013 Port busy  output  1  high whenever the state is not IDLE.

Function
REQ-014 States SHALL be IDLE, SEND, and (with UART_ARB_LOCK_EN only) LOCKED; encoding is free.
REQ-015 Handshake: a transfer on either side occurs exactly when valid and ready are both high on a rising edge.
REQ-016 In IDLE with any req_valid high, the block SHALL select winner w round-robin, searching upward from (last_grant+1) mod NUM_REQ with wrap-around.
REQ-017 In that same cycle req_ready[w] SHALL be 1 (combinational from req_valid), all other req_ready bits 0; on the edge tx_data<=req_data[w], grant_id<=w, last_grant<=w, state<=SEND.
REQ-018 req_ready SHALL be all-zero in SEND; at most one req_ready bit is high in any cycle.
REQ-019 In SEND tx_valid SHALL be 1 and tx_data/grant_id SHALL hold stable until tx_ready is sampled high.
REQ-020 Latency: byte accepted in cycle N appears with tx_valid=1 in cycle N+1; with tx_ready held high, tx_valid falls in N+2; max throughput one byte per 2 cycles.
REQ-021 On the SEND transfer edge the state SHALL return to IDLE (or LOCKED, REQ-027); tx_valid=0 in IDLE and LOCKED.
REQ-022 A requester deasserting req_valid before acceptance SHALL simply not be granted; no byte is lost or duplicated.
REQ-023 With no req_valid in IDLE the block SHALL stay in IDLE with last_grant unchanged.
REQ-024 tx_ready high while tx_valid=0 SHALL have no effect.

Reset
REQ-025 On reset: state=IDLE, tx_valid=0, tx_data=0, grant_id=0, req_ready=0, busy=0, last_grant=NUM_REQ-1 (requester 0 highest priority first).
REQ-026 Reset during SEND or LOCKED SHALL discard the buffered byte and any lock; tx_valid is 0 in the cycle after reset is sampled.

Configuration
REQ-027 Macro UART_ARB_LOCK_EN defined: if the byte accepted from w had req_last[w]=0, after its SEND completes the state SHALL be LOCKED; in LOCKED only requester w is considered (req_ready[w]=req_valid[w], others 0), acceptance moves to SEND; a byte with req_last=1 returns to IDLE after its SEND.
REQ-028 Macro UART_ARB_LOCK_EN undefined: req_last SHALL be ignored, LOCKED does not exist, and every byte is arbitrated independently per REQ-016.

Verification
REQ-029 After reset, req_valid=4'b1111 held, tx_ready=1 -> grant_id sequence 0,1,2,3,0 and tx_data matches each requester's byte.
REQ-030 Single req_valid[2]=1, data 8'hA5, tx_ready=0 for 5 cycles then 1 -> tx_valid high 6 cycles, tx_data=8'hA5 stable, req_ready[2] pulses once.
REQ-031 tx_ready=1 constantly, requester 1 streaming 8'h10..8'h13 -> tx_valid every other cycle, bytes in order, none duplicated.
REQ-032 Reset asserted one cycle into SEND with byte 8'h5A -> next cycle tx_valid=0, busy=0; first grant after reset goes to lowest-index active requester.
REQ-033 LOCK_EN defined: requester 0 sends 3 bytes (req_last on third) while requester 1 valid -> requester 1 granted only after third byte; LOCK_EN undefined -> grants alternate 0,1,0,1.
REQ-034 req_valid[3] pulsed one cycle while in SEND -> no req_ready[3], no extra tx transfer.
